// File: rtl/dynamic_branch_predictor.sv
// -----------------------------------------------------------------------------
// dynamic_branch_predictor
//
// Fetch-stage branch predictor for the 5-stage WISC pipeline. It holds a direct
// mapped branch history table (BHT) of 2-bit saturating counters and a branch
// target buffer (BTB). Both are indexed by PC[3:1] and tagged with the full PC.
//
// Lookup (IF stage) is purely combinational from the registered arrays, so IF
// gets a taken/target guess in the same cycle as PC_curr. Resolution updates
// from ID are written on the clock edge and become visible one cycle later.
// There is no read/write bypass.
//
// Ports
//   clk                    system clock, all state changes on posedge
//   rst                    synchronous active-high reset
//   PC_curr                IF-stage PC being looked up
//   IF_ID_PC_curr          PC of the branch resolving in ID
//   wen_BHT                ID resolved a branch: update its BHT entry
//   wen_BTB                ID resolved a taken branch: write its BTB entry
//   actual_taken           resolved direction
//   actual_target          resolved target address
//   IF_ID_predicted_taken  direction that was predicted for IF_ID_PC_curr
//   IF_ID_predicted_target target that was predicted for IF_ID_PC_curr
//   prediction             counter state for PC_curr (00 SNT .. 11 ST)
//   predicted_taken        BHT hit, counter says taken, and BTB hit
//   predicted_target       BTB target when predicted_taken, else 0x0000
//   mispredicted           combinational flush request for the branch in ID
//   update_count           saturating count of BHT updates
//   mispredict_count       saturating count of mispredictions
// -----------------------------------------------------------------------------
module dynamic_branch_predictor #(
  parameter int NUM_ENTRIES = 8,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       PC_curr,
  input  logic [15:0]       IF_ID_PC_curr,
  input  logic              wen_BHT,
  input  logic              wen_BTB,
  input  logic              actual_taken,
  input  logic [15:0]       actual_target,
  input  logic              IF_ID_predicted_taken,
  input  logic [15:0]       IF_ID_predicted_target,
  output logic [1:0]        prediction,
  output logic              predicted_taken,
  output logic [15:0]       predicted_target,
  output logic              mispredicted,
  output logic [STAT_W-1:0] update_count,
  output logic [STAT_W-1:0] mispredict_count
);

  // Index width: PC[IDX_W:1] selects the entry (PC[0] is always 0 for
  // halfword-aligned instructions, so it is skipped).
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic        bht_valid_q [NUM_ENTRIES];
  logic [15:0] bht_pc_q    [NUM_ENTRIES];
  logic [1:0]  bht_state_q [NUM_ENTRIES];

  logic        btb_valid_q [NUM_ENTRIES];
  logic [15:0] btb_pc_q    [NUM_ENTRIES];
  logic [15:0] btb_tgt_q   [NUM_ENTRIES];

  logic [STAT_W-1:0] update_cnt_q, update_cnt_d;
  logic [STAT_W-1:0] mis_cnt_q,    mis_cnt_d;

  // ---------------------------------------------------------------------------
  // Lookup path (IF)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lidx;
  logic             bht_hit;
  logic             btb_hit;

  assign lidx    = PC_curr[IDX_W:1];
  assign bht_hit = bht_valid_q[lidx] && (bht_pc_q[lidx] == PC_curr);
  assign btb_hit = btb_valid_q[lidx] && (btb_pc_q[lidx] == PC_curr);

  assign prediction       = bht_hit ? bht_state_q[lidx] : 2'b00;
  assign predicted_taken  = bht_hit && bht_state_q[lidx][1] && btb_hit;
  assign predicted_target = predicted_taken ? btb_tgt_q[lidx] : 16'h0000;

  // ---------------------------------------------------------------------------
  // Misprediction detect (ID). Depends only on the ID-stage inputs, never on
  // the arrays, so it is stable as soon as the resolution inputs are.
  // ---------------------------------------------------------------------------
  assign mispredicted = wen_BHT &&
                        ((IF_ID_predicted_taken != actual_taken) ||
                         (actual_taken && (IF_ID_predicted_target != actual_target)));

  // ---------------------------------------------------------------------------
  // Update path (ID): one shared next-state value, written into the single
  // entry selected by uidx.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] uidx;
  logic             upd_hit;
  logic [1:0]       upd_state_old;
  logic [1:0]       bht_state_new;

  assign uidx          = IF_ID_PC_curr[IDX_W:1];
  assign upd_state_old = bht_state_q[uidx];
  assign upd_hit       = bht_valid_q[uidx] && (bht_pc_q[uidx] == IF_ID_PC_curr);

  always_comb begin
    bht_state_new = upd_state_old;
    if (upd_hit) begin
      // Saturating step of the 2-bit counter.
      if (actual_taken) begin
        if (upd_state_old != 2'b11) begin
          bht_state_new = upd_state_old + 2'b01;
        end
      end else begin
        if (upd_state_old != 2'b00) begin
          bht_state_new = upd_state_old - 2'b01;
        end
      end
    end else begin
      // Fresh allocation starts in the weak state of the observed direction.
      bht_state_new = actual_taken ? 2'b10 : 2'b01;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      logic bht_we;
      logic btb_we;

      assign bht_we = wen_BHT && (uidx == IDX_W'(gi));
      assign btb_we = wen_BTB && (uidx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          bht_valid_q[gi] <= 1'b0;
          bht_pc_q[gi]    <= 16'h0000;
          bht_state_q[gi] <= 2'b00;
        end else if (bht_we) begin
          bht_valid_q[gi] <= 1'b1;
          bht_pc_q[gi]    <= IF_ID_PC_curr;
          bht_state_q[gi] <= bht_state_new;
        end
      end

      // The BTB entry is overwritten unconditionally; a tag miss simply
      // replaces whatever aliased branch lived there.
      always_ff @(posedge clk) begin
        if (rst) begin
          btb_valid_q[gi] <= 1'b0;
          btb_pc_q[gi]    <= 16'h0000;
          btb_tgt_q[gi]   <= 16'h0000;
        end else if (btb_we) begin
          btb_valid_q[gi] <= 1'b1;
          btb_pc_q[gi]    <= IF_ID_PC_curr;
          btb_tgt_q[gi]   <= actual_target;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Statistics: saturate at all-ones so a long run never wraps back to a small
  // misleading number.
  // ---------------------------------------------------------------------------
  always_comb begin
    update_cnt_d = update_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (wen_BHT && (update_cnt_q != {STAT_W{1'b1}})) begin
      update_cnt_d = update_cnt_q + 1'b1;
    end
    if (mispredicted && (mis_cnt_q != {STAT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      update_cnt_q <= update_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign update_count     = update_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// -----------------------------------------------------------------------------
// Testbench for dynamic_branch_predictor. Directed scenarios followed by a
// randomized run, all checked against a table-level model of the predictor
// (per-index valid/tag/counter/target records updated with plain arithmetic).
// Inputs change 1 ns after the rising edge; outputs are checked in between.
// -----------------------------------------------------------------------------
module tb_dynamic_branch_predictor;

  localparam int SW = 4;  // small counters so saturation is reachable

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   PC_curr;
  logic [15:0]   IF_ID_PC_curr;
  logic          wen_BHT;
  logic          wen_BTB;
  logic          actual_taken;
  logic [15:0]   actual_target;
  logic          IF_ID_predicted_taken;
  logic [15:0]   IF_ID_predicted_target;
  logic [1:0]    prediction;
  logic          predicted_taken;
  logic [15:0]   predicted_target;
  logic          mispredicted;
  logic [SW-1:0] update_count;
  logic [SW-1:0] mispredict_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dynamic_branch_predictor #(.NUM_ENTRIES(8), .STAT_W(SW)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .PC_curr                (PC_curr),
    .IF_ID_PC_curr          (IF_ID_PC_curr),
    .wen_BHT                (wen_BHT),
    .wen_BTB                (wen_BTB),
    .actual_taken           (actual_taken),
    .actual_target          (actual_target),
    .IF_ID_predicted_taken  (IF_ID_predicted_taken),
    .IF_ID_predicted_target (IF_ID_predicted_target),
    .prediction             (prediction),
    .predicted_taken        (predicted_taken),
    .predicted_target       (predicted_target),
    .mispredicted           (mispredicted),
    .update_count           (update_count),
    .mispredict_count       (mispredict_count)
  );

  // ---------------------------------------------------------------------------
  // Reference model: one record per index.
  // ---------------------------------------------------------------------------
  bit          m_bv  [8];
  logic [15:0] m_bpc [8];
  int          m_bst [8];
  bit          m_tv  [8];
  logic [15:0] m_tpc [8];
  logic [15:0] m_ttg [8];
  int          m_ucnt;
  int          m_mcnt;
  localparam int CMAX = (1 << SW) - 1;

  function automatic logic [1:0] m_pred(logic [15:0] pc);
    int i = int'(pc[3:1]);
    return (m_bv[i] && m_bpc[i] == pc) ? 2'(m_bst[i]) : 2'b00;
  endfunction

  function automatic logic m_taken(logic [15:0] pc);
    int i = int'(pc[3:1]);
    return (m_pred(pc) >= 2'b10) && m_tv[i] && (m_tpc[i] == pc);
  endfunction

  function automatic logic [15:0] m_target(logic [15:0] pc);
    int i = int'(pc[3:1]);
    return m_taken(pc) ? m_ttg[i] : 16'h0000;
  endfunction

  function automatic logic m_mis();
    return wen_BHT && ((IF_ID_predicted_taken != actual_taken) ||
                       (actual_taken && IF_ID_predicted_target != actual_target));
  endfunction

  task automatic model_update();
    int i = int'(IF_ID_PC_curr[3:1]);
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        m_bv[k] = 0; m_bpc[k] = 0; m_bst[k] = 0;
        m_tv[k] = 0; m_tpc[k] = 0; m_ttg[k] = 0;
      end
      m_ucnt = 0;
      m_mcnt = 0;
    end else begin
      if (wen_BHT) begin
        if (m_mis()) m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
        m_ucnt = (m_ucnt < CMAX) ? m_ucnt + 1 : CMAX;
        if (m_bv[i] && m_bpc[i] == IF_ID_PC_curr) begin
          m_bst[i] = actual_taken ? ((m_bst[i] < 3) ? m_bst[i] + 1 : 3)
                                  : ((m_bst[i] > 0) ? m_bst[i] - 1 : 0);
        end else begin
          m_bv[i]  = 1;
          m_bpc[i] = IF_ID_PC_curr;
          m_bst[i] = actual_taken ? 2 : 1;
        end
      end
      if (wen_BTB) begin
        m_tv[i]  = 1;
        m_tpc[i] = IF_ID_PC_curr;
        m_ttg[i] = actual_target;
      end
    end
  endtask

  // Advance one clock, mirroring the edge into the model.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wen_BHT = 0; wen_BTB = 0; actual_taken = 0; actual_target = 0;
    IF_ID_predicted_taken = 0; IF_ID_predicted_target = 0;
  endtask

  task automatic set_update(input logic [15:0] pc, input logic bht, input logic btb,
                            input logic tk, input logic [15:0] tgt,
                            input logic ptk, input logic [15:0] ptgt);
    IF_ID_PC_curr = pc; wen_BHT = bht; wen_BTB = btb;
    actual_taken = tk; actual_target = tgt;
    IF_ID_predicted_taken = ptk; IF_ID_predicted_target = ptgt;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    IF_ID_PC_curr = 16'h0000;
    rst = 1; PC_curr = 16'h0004;
    tick(); tick();
    rst = 0;
    #1;
    n_total++;
    if (prediction !== 2'b00 || predicted_taken !== 1'b0 || predicted_target !== 16'h0000) begin
      $display("FAIL reset_lookup got pred=%b tk=%b tgt=%h exp pred=00 tk=0 tgt=0000",
               prediction, predicted_taken, predicted_target);
    end else n_pass++;
    n_total++;
    if (update_count !== '0 || mispredict_count !== '0 || mispredicted !== 1'b0) begin
      $display("FAIL reset_counts got upd=%0d mis=%0d misp=%b exp 0 0 0",
               update_count, mispredict_count, mispredicted);
    end else n_pass++;
  endtask

  task automatic test_allocate();
    PC_curr = 16'h0010;
    set_update(16'h0010, 1, 1, 1, 16'h0040, 0, 16'h0000);
    #1;
    n_total++;
    if (mispredicted !== 1'b1) $display("FAIL alloc_mispredicted got=%b exp=1", mispredicted);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (prediction !== 2'b10 || predicted_taken !== 1'b1 || predicted_target !== 16'h0040) begin
      $display("FAIL alloc_lookup got pred=%b tk=%b tgt=%h exp pred=10 tk=1 tgt=0040",
               prediction, predicted_taken, predicted_target);
    end else n_pass++;
    n_total++;
    if (mispredict_count !== 4'd1 || update_count !== 4'd1) begin
      $display("FAIL alloc_counts got upd=%0d mis=%0d exp 1 1", update_count, mispredict_count);
    end else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_st [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    logic       exp_tk [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    PC_curr = 16'h0010;
    for (int s = 0; s < 7; s++) begin
      if (s < 4) set_update(16'h0010, 1, 1, 1, 16'h0040, 1, 16'h0040);
      else       set_update(16'h0010, 1, 0, 0, 16'h0000, m_taken(16'h0010), m_target(16'h0010));
      tick();
      idle_inputs();
      #1;
      n_total++;
      if (prediction !== exp_st[s] || predicted_taken !== exp_tk[s]) begin
        $display("FAIL sat_step%0d got pred=%b tk=%b exp pred=%b tk=%b",
                 s, prediction, predicted_taken, exp_st[s], exp_tk[s]);
      end else n_pass++;
    end
    n_total++;
    if (int'(mispredict_count) != m_mcnt || int'(update_count) != m_ucnt) begin
      $display("FAIL sat_counts got upd=%0d mis=%0d exp %0d %0d",
               update_count, mispredict_count, m_ucnt, m_mcnt);
    end else n_pass++;
  endtask

  task automatic test_alias();
    set_update(16'h0010, 1, 1, 1, 16'h0040, 0, 16'h0000);
    tick();
    set_update(16'h0020, 1, 0, 0, 16'h0000, 0, 16'h0000);
    tick();
    idle_inputs();
    PC_curr = 16'h0010;
    #1;
    n_total++;
    if (prediction !== 2'b00 || predicted_taken !== 1'b0 || predicted_target !== 16'h0000) begin
      $display("FAIL alias_evicted got pred=%b tk=%b tgt=%h exp 00 0 0000",
               prediction, predicted_taken, predicted_target);
    end else n_pass++;
    PC_curr = 16'h0020;
    #1;
    n_total++;
    if (prediction !== 2'b01 || predicted_taken !== 1'b0) begin
      $display("FAIL alias_new got pred=%b tk=%b exp 01 0", prediction, predicted_taken);
    end else n_pass++;
  endtask

  task automatic test_same_cycle();
    set_update(16'h0010, 1, 1, 1, 16'h0040, 0, 16'h0000);  // re-allocate -> 10
    tick();
    PC_curr = 16'h0010;
    set_update(16'h0010, 1, 1, 1, 16'h0040, 1, 16'h0040);  // 10 -> 11
    #1;
    n_total++;
    if (prediction !== 2'b10) $display("FAIL same_cycle_old got=%b exp=10", prediction);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (prediction !== 2'b11) $display("FAIL same_cycle_new got=%b exp=11", prediction);
    else n_pass++;
  endtask

  task automatic test_target_mismatch();
    PC_curr = 16'h0010;
    #1;
    n_total++;
    if (predicted_taken !== 1'b1 || predicted_target !== 16'h0040) begin
      $display("FAIL tgt_pre got tk=%b tgt=%h exp 1 0040", predicted_taken, predicted_target);
    end else n_pass++;
    // Right direction, right target: no flush.
    set_update(16'h0010, 1, 1, 1, 16'h0040, 1, 16'h0040);
    #1;
    n_total++;
    if (mispredicted !== 1'b0) $display("FAIL tgt_match got=%b exp=0", mispredicted);
    else n_pass++;
    // Mismatch without wen_BHT must not flush.
    set_update(16'h0010, 0, 0, 1, 16'h0050, 0, 16'h0040);
    #1;
    n_total++;
    if (mispredicted !== 1'b0) $display("FAIL tgt_nowen got=%b exp=0", mispredicted);
    else n_pass++;
    set_update(16'h0010, 1, 1, 1, 16'h0050, 1, 16'h0040);
    #1;
    n_total++;
    if (mispredicted !== 1'b1) $display("FAIL tgt_mismatch got=%b exp=1", mispredicted);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (predicted_taken !== 1'b1 || predicted_target !== 16'h0050) begin
      $display("FAIL tgt_post got tk=%b tgt=%h exp 1 0050", predicted_taken, predicted_target);
    end else n_pass++;
  endtask

  task automatic test_reset_priority();
    rst = 1;
    set_update(16'h000A, 1, 1, 1, 16'h0080, 0, 16'h0000);
    tick();
    rst = 0;
    idle_inputs();
    PC_curr = 16'h000A;
    #1;
    n_total++;
    if (prediction !== 2'b00 || predicted_taken !== 1'b0 || predicted_target !== 16'h0000 ||
        update_count !== '0 || mispredict_count !== '0) begin
      $display("FAIL rst_priority got pred=%b tk=%b tgt=%h upd=%0d mis=%0d exp 00 0 0000 0 0",
               prediction, predicted_taken, predicted_target, update_count, mispredict_count);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] pc_u;
    logic [15:0] tgt;
    logic        tk;
    int          errs = 0;
    for (int c = 0; c < 400; c++) begin
      pc_u = 16'($urandom_range(0, 11)) << 1;
      PC_curr = ($urandom_range(0, 3) == 0) ? pc_u : (16'($urandom_range(0, 11)) << 1);
      tk  = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 1) == 0) ? 16'h0040 : 16'($urandom_range(0, 3) * 16);
      if ($urandom_range(0, 1) == 0)
        set_update(pc_u, ($urandom_range(0, 9) < 7), 1'b0, tk, tgt, m_taken(pc_u), m_target(pc_u));
      else
        set_update(pc_u, ($urandom_range(0, 9) < 7), 1'b0, tk, tgt,
                   1'($urandom_range(0, 1)), 16'($urandom_range(0, 3) * 16));
      wen_BTB = wen_BHT ? tk : ($urandom_range(0, 7) == 0);
      #1;
      n_total++;
      if (prediction !== m_pred(PC_curr) || predicted_taken !== m_taken(PC_curr) ||
          predicted_target !== m_target(PC_curr) || mispredicted !== m_mis() ||
          int'(update_count) != m_ucnt || int'(mispredict_count) != m_mcnt) begin
        if (errs < 10) begin
          $display("FAIL random c=%0d pc=%h got pred=%b tk=%b tgt=%h misp=%b upd=%0d mis=%0d exp pred=%b tk=%b tgt=%h misp=%b upd=%0d mis=%0d",
                   c, PC_curr, prediction, predicted_taken, predicted_target, mispredicted,
                   update_count, mispredict_count, m_pred(PC_curr), m_taken(PC_curr),
                   m_target(PC_curr), m_mis(), m_ucnt, m_mcnt);
        end
        errs++;
      end else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    PC_curr = 0;
    IF_ID_PC_curr = 0;
    idle_inputs();
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_target_mismatch();
    test_reset_priority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
